// File: rtl/bcd_updown_counter.sv
// Multi-digit cascaded BCD up/down counter with load, clear, wrap/saturate
// mode, combinational terminal-count and registered carry/load-error pulses.
module bcd_updown_counter #(
  parameter int DIGITS = 2,
  parameter bit WRAP   = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  up,
  input  logic                  clr,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   count,
  output logic                  tc,
  output logic                  co,
  output logic                  load_err
);
  localparam int W = 4 * DIGITS;

  logic [W-1:0]    count_reg;
  logic [W-1:0]    step_val;
  logic [W-1:0]    load_fix;
  logic [DIGITS:0] nine_chain;
  logic [DIGITS:0] zero_chain;
  logic [DIGITS-1:0] bad_nib;
  logic            co_reg;
  logic            load_err_reg;
  logic            terminal;

  // nine_chain[i] / zero_chain[i]: every digit below i is 9 / 0, i.e. digit i
  // receives the ripple carry / borrow this cycle.
  assign nine_chain[0] = 1'b1;
  assign zero_chain[0] = 1'b1;

  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
      logic [3:0] d;
      logic [3:0] lv;
      logic [3:0] d_up;
      logic [3:0] d_dn;
      logic       step;

      assign d    = count_reg[4*gi +: 4];
      assign lv   = load_val[4*gi +: 4];
      assign nine_chain[gi+1] = nine_chain[gi] & (d == 4'd9);
      assign zero_chain[gi+1] = zero_chain[gi] & (d == 4'd0);

      assign step = up ? nine_chain[gi] : zero_chain[gi];
      assign d_up = (d == 4'd9) ? 4'd0 : d + 4'd1;
      assign d_dn = (d == 4'd0) ? 4'd9 : d - 4'd1;
      assign step_val[4*gi +: 4] = step ? (up ? d_up : d_dn) : d;

      assign bad_nib[gi] = (lv > 4'd9);
      assign load_fix[4*gi +: 4] = bad_nib[gi] ? 4'd0 : lv;
    end
  endgenerate

  assign terminal = up ? nine_chain[DIGITS] : zero_chain[DIGITS];
  assign tc       = en & terminal;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_reg    <= '0;
      co_reg       <= 1'b0;
      load_err_reg <= 1'b0;
    end else if (clr) begin
      count_reg    <= '0;
      co_reg       <= 1'b0;
      load_err_reg <= 1'b0;
    end else if (load) begin
      count_reg    <= load_fix;
      co_reg       <= 1'b0;
      load_err_reg <= |bad_nib;
    end else begin
      co_reg       <= 1'b0;
      load_err_reg <= 1'b0;
      // In saturate mode a step at the terminal value is suppressed entirely.
      if (en && (WRAP || !terminal)) begin
        count_reg <= step_val;
        co_reg    <= terminal;
      end
    end
  end

  assign count    = count_reg;
  assign co       = co_reg;
  assign load_err = load_err_reg;

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Self-checking bench: directed vector table on 2-digit wrap/saturate builds,
// mid-cycle async reset sequences, and a 4-digit random run vs a decimal model.
module tb_bcd_updown_counter;
  logic        clk = 1'b0;
  logic        reset, en, up, clr, load;
  logic [15:0] load_val;
  logic [7:0]  cnt_w, cnt_s;
  logic [15:0] cnt4;
  logic        tc_w, co_w, le_w, tc_s, co_s, le_s, tc4, co4, le4;
  int          n_chk = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  bcd_updown_counter #(.DIGITS(2), .WRAP(1'b1)) dut_w (
    .clk(clk), .reset(reset), .en(en), .up(up), .clr(clr), .load(load),
    .load_val(load_val[7:0]), .count(cnt_w), .tc(tc_w), .co(co_w), .load_err(le_w));

  bcd_updown_counter #(.DIGITS(2), .WRAP(1'b0)) dut_s (
    .clk(clk), .reset(reset), .en(en), .up(up), .clr(clr), .load(load),
    .load_val(load_val[7:0]), .count(cnt_s), .tc(tc_s), .co(co_s), .load_err(le_s));

  bcd_updown_counter #(.DIGITS(4), .WRAP(1'b1)) dut_4 (
    .clk(clk), .reset(reset), .en(en), .up(up), .clr(clr), .load(load),
    .load_val(load_val), .count(cnt4), .tc(tc4), .co(co4), .load_err(le4));

  typedef struct {
    logic       en, up, clr, load;
    logic [7:0] lv;
    logic [7:0] cw;
    logic       tw, ow;
    logic [7:0] cs;
    logic       ts, os;
    logic       le;
  } vec_t;

  vec_t vt[23];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic e, input logic u, input logic c, input logic l,
                       input logic [15:0] lv);
    en = e; up = u; clr = c; load = l; load_val = lv;
  endtask

  function automatic vec_t mk(input logic e, input logic u, input logic c, input logic l,
                              input logic [7:0] lv, input logic [7:0] cw, input logic tw,
                              input logic ow, input logic [7:0] cs, input logic ts,
                              input logic os, input logic le);
    vec_t v;
    v.en = e; v.up = u; v.clr = c; v.load = l; v.lv = lv;
    v.cw = cw; v.tw = tw; v.ow = ow; v.cs = cs; v.ts = ts; v.os = os; v.le = le;
    return v;
  endfunction

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    int t;
    t = v;
    for (int k = 0; k < 4; k++) begin
      r[4*k +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  // Load lv, then assert reset mid-cycle with en=1 and expect an immediate clear.
  task automatic mid_reset(input logic [7:0] lv, input logic [7:0] exp_ld, input logic exp_le);
    drive(1'b0, 1'b1, 1'b0, 1'b1, {8'h00, lv});
    @(posedge clk); #1;
    chk("midrst_load_count", cnt_w, exp_ld);
    chk("midrst_load_err", le_w, exp_le);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 16'h0);
    reset = 1'b1;
    #2;
    chk("midrst_async_count", cnt_w, 8'h00);
    chk("midrst_async_co", co_w, 1'b0);
    chk("midrst_async_le", le_w, 1'b0);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("midrst_first_count", cnt_w, 8'h01);
  endtask

  initial begin
    int m;
    logic e, u, c, l;
    logic [15:0] lv;
    logic exp_tc, exp_co, exp_le, nib_ok;
    logic [3:0] nib;

    //            en  up  clr ld  lv     cw     tw  ow  cs     ts  os  le
    vt[0]  = mk(0, 1, 0, 1, 8'h97, 8'h97, 0, 0, 8'h97, 0, 0, 0);
    vt[1]  = mk(1, 1, 0, 0, 8'h00, 8'h98, 0, 0, 8'h98, 0, 0, 0);
    vt[2]  = mk(1, 1, 0, 0, 8'h00, 8'h99, 0, 0, 8'h99, 0, 0, 0);
    vt[3]  = mk(1, 1, 0, 0, 8'h00, 8'h00, 1, 1, 8'h99, 1, 0, 0);
    vt[4]  = mk(1, 1, 0, 0, 8'h00, 8'h01, 0, 0, 8'h99, 1, 0, 0);
    vt[5]  = mk(0, 0, 0, 1, 8'h10, 8'h10, 0, 0, 8'h10, 0, 0, 0);
    vt[6]  = mk(1, 0, 0, 0, 8'h00, 8'h09, 0, 0, 8'h09, 0, 0, 0);
    vt[7]  = mk(0, 0, 0, 1, 8'h01, 8'h01, 0, 0, 8'h01, 0, 0, 0);
    vt[8]  = mk(1, 0, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 0, 0, 0);
    vt[9]  = mk(1, 0, 0, 0, 8'h00, 8'h99, 1, 1, 8'h00, 1, 0, 0);
    vt[10] = mk(1, 0, 0, 0, 8'h00, 8'h98, 0, 0, 8'h00, 1, 0, 0);
    vt[11] = mk(0, 0, 0, 1, 8'h4C, 8'h40, 0, 0, 8'h40, 0, 0, 1);
    vt[12] = mk(0, 0, 0, 0, 8'h00, 8'h40, 0, 0, 8'h40, 0, 0, 0);
    vt[13] = mk(0, 0, 1, 1, 8'h55, 8'h00, 0, 0, 8'h00, 0, 0, 0);
    vt[14] = mk(1, 1, 0, 1, 8'h9A, 8'h90, 0, 0, 8'h90, 0, 0, 1);
    vt[15] = mk(1, 1, 1, 0, 8'h00, 8'h00, 0, 0, 8'h00, 0, 0, 0);
    vt[16] = mk(0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 0, 0, 0);
    vt[17] = mk(1, 0, 1, 0, 8'h00, 8'h00, 1, 0, 8'h00, 1, 0, 0);
    vt[18] = mk(0, 0, 0, 1, 8'h99, 8'h99, 0, 0, 8'h99, 0, 0, 0);
    vt[19] = mk(1, 1, 0, 1, 8'h99, 8'h99, 1, 0, 8'h99, 1, 0, 0);
    vt[20] = mk(1, 0, 0, 0, 8'h00, 8'h98, 0, 0, 8'h98, 0, 0, 0);
    vt[21] = mk(1, 1, 0, 0, 8'h00, 8'h99, 0, 0, 8'h99, 0, 0, 0);
    vt[22] = mk(1, 1, 0, 0, 8'h00, 8'h00, 1, 1, 8'h99, 1, 0, 0);

    // Reset held for 3 cycles with en=1, then release.
    reset = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 1'b0, 16'h0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("rst_count_w", cnt_w, 8'h00);
      chk("rst_co_w", co_w, 1'b0);
      chk("rst_count_s", cnt_s, 8'h00);
      chk("rst_le_w", le_w, 1'b0);
    end
    reset = 1'b0;
    @(posedge clk); #1;
    chk("rst_release_w", cnt_w, 8'h01);
    chk("rst_release_s", cnt_s, 8'h01);
    $display("reset release: count_w=%h count_s=%h", cnt_w, cnt_s);

    for (int i = 0; i < 23; i++) begin
      drive(vt[i].en, vt[i].up, vt[i].clr, vt[i].load, {8'h00, vt[i].lv});
      #1;
      chk($sformatf("v%0d_tc_w", i), tc_w, vt[i].tw);
      chk($sformatf("v%0d_tc_s", i), tc_s, vt[i].ts);
      @(posedge clk); #1;
      chk($sformatf("v%0d_count_w", i), cnt_w, vt[i].cw);
      chk($sformatf("v%0d_co_w", i), co_w, vt[i].ow);
      chk($sformatf("v%0d_le_w", i), le_w, vt[i].le);
      chk($sformatf("v%0d_count_s", i), cnt_s, vt[i].cs);
      chk($sformatf("v%0d_co_s", i), co_s, vt[i].os);
      chk($sformatf("v%0d_le_s", i), le_s, vt[i].le);
      $display("vec %0d: en=%b up=%b clr=%b load=%b lv=%h -> w=%h co=%b s=%h le=%b",
               i, vt[i].en, vt[i].up, vt[i].clr, vt[i].load, vt[i].lv, cnt_w, co_w, cnt_s, le_w);
    end

    mid_reset(8'h55, 8'h55, 1'b0);
    $display("mid-cycle reset from 55: count_w=%h", cnt_w);
    mid_reset(8'h5C, 8'h50, 1'b1);
    $display("mid-cycle reset from 5C load: count_w=%h", cnt_w);

    // 4-digit random run against a decimal reference.
    drive(1'b0, 1'b1, 1'b0, 1'b0, 16'h0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    m = 0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      e = ($urandom_range(0, 9) < 7);
      u = 1'($urandom_range(0, 1));
      c = ($urandom_range(0, 49) == 0);
      l = ($urandom_range(0, 19) == 0);
      case ($urandom_range(0, 3))
        0: lv = 16'h9999;
        1: lv = 16'h0000;
        2: lv = 16'h9998;
        default: lv = 16'($urandom);
      endcase
      drive(e, u, c, l, lv);
      exp_tc = e && (u ? (m == 9999) : (m == 0));
      exp_co = 1'b0;
      exp_le = 1'b0;
      if (c) begin
        m = 0;
      end else if (l) begin
        m = 0;
        for (int k = 3; k >= 0; k--) begin
          nib = lv[4*k +: 4];
          if (nib > 4'd9) begin
            exp_le = 1'b1;
            nib = 4'd0;
          end
          m = m * 10 + int'(nib);
        end
      end else if (e) begin
        if (u) begin
          if (m == 9999) begin m = 0; exp_co = 1'b1; end
          else m = m + 1;
        end else begin
          if (m == 0) begin m = 9999; exp_co = 1'b1; end
          else m = m - 1;
        end
      end
      #1;
      chk("rnd_tc", tc4, exp_tc);
      @(posedge clk); #1;
      chk("rnd_count", cnt4, to_bcd(m));
      chk("rnd_co", co4, exp_co);
      chk("rnd_le", le4, exp_le);
      nib_ok = 1'b1;
      for (int k = 0; k < 4; k++) if (cnt4[4*k +: 4] > 4'd9) nib_ok = 1'b0;
      chk("rnd_nibble_legal", nib_ok, 1'b1);
    end
    $display("random run: 10000 cycles, final count=%h model=%0d", cnt4, m);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
